// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Issues a set of active-high stage resets and releases them one at a time,
// stage 0 first. All stages are held for HOLD_CYCLES after reset or after a
// software request. The remaining stages then drop every STAGE_GAP cycles.
// A software request forces every stage back into reset and reruns the
// sequence.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset (already release-synchronized)
//   sw_rst_req : level software reset request, synchronous to clk
//   rst_out    : registered active-high stage resets [N_STAGES-1:0]
//   seq_done   : high once every stage is released
//   busy       : inverse of seq_done
//
// States
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_ASSERT  | all stages in reset, hold counter running
//   ST_RELEASE | stages dropping one by one, idx_q = next stage to drop
//   ST_DONE    | all stages released, seq_done high
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int N_STAGES    = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sw_rst_req,
    output logic [N_STAGES-1:0] rst_out,
    output logic                seq_done,
    output logic                busy
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(N_STAGES + 1);

    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_STAGES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_STAGES-1:0] rst_out_q, rst_out_d;
    logic                seq_done_q, seq_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= '0;
            idx_q      <= IDX_W'(1);
            rst_out_q  <= '1;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rst_out_q  <= rst_out_d;
            seq_done_q <= seq_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rst_out_d  = rst_out_q;
        seq_done_d = seq_done_q;

        if (sw_rst_req) begin
            // Reload every cycle while the request is held; the hold count
            // only starts on the first cycle the request is low.
            state_d    = ST_ASSERT;
            cnt_d      = '0;
            idx_d      = IDX_W'(1);
            rst_out_d  = '1;
            seq_done_d = 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == HOLD_TC) begin
                        rst_out_d[0] = 1'b0;
                        cnt_d        = '0;
                        if (N_STAGES == 1) begin
                            state_d    = ST_DONE;
                            seq_done_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_RELEASE: begin
                    if (cnt_q == GAP_TC) begin
                        // Loop form keeps the index within range for any
                        // N_STAGES, including configurations where this
                        // state is unreachable.
                        for (int i = 0; i < N_STAGES; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                rst_out_d[i] = 1'b0;
                            end
                        end
                        cnt_d = '0;
                        if (idx_q == IDX_MAX) begin
                            state_d    = ST_DONE;
                            seq_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    state_d = ST_DONE;
                end

                default: begin
                    state_d    = ST_ASSERT;
                    cnt_d      = '0;
                    idx_d      = IDX_W'(1);
                    rst_out_d  = '1;
                    seq_done_d = 1'b0;
                end
            endcase
        end
    end

    assign rst_out  = rst_out_q;
    assign seq_done = seq_done_q;
    assign busy     = ~seq_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Two instances: A uses the default configuration (3 stages, hold 16, gap 4),
// B uses a single stage with a one-cycle hold. The reference model counts
// qualifying edges since the last restart and derives each stage's state
// from the release-edge formula HOLD + k*GAP.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int A_N = 3, A_H = 16, A_G = 4;
    localparam int B_N = 1, B_H = 1,  B_G = 4;

    logic           clk;
    logic           rst_n;
    logic           sw_a, sw_b;
    logic [A_N-1:0] rst_out_a;
    logic [B_N-1:0] rst_out_b;
    logic           done_a, busy_a, done_b, busy_b;

    int n_cmp = 0;
    int n_bad = 0;
    int t_a   = 0;
    int t_b   = 0;

    reset_sequencer #(.N_STAGES(A_N), .HOLD_CYCLES(A_H), .STAGE_GAP(A_G)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (sw_a),
        .rst_out    (rst_out_a),
        .seq_done   (done_a),
        .busy       (busy_a)
    );

    reset_sequencer #(.N_STAGES(B_N), .HOLD_CYCLES(B_H), .STAGE_GAP(B_G)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (sw_b),
        .rst_out    (rst_out_b),
        .seq_done   (done_b),
        .busy       (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stage k is still in reset while fewer than HOLD + k*GAP qualifying
    // edges have elapsed since the last restart.
    function automatic logic [7:0] exp_out(int t, int n, int h, int g);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[k] = (t < h + k * g);
        return r;
    endfunction

    function automatic logic exp_done(int t, int n, int h, int g);
        return (t >= h + (n - 1) * g);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        check("a_rst_out_model", 8'(rst_out_a), exp_out(t_a, A_N, A_H, A_G));
        check("a_seq_done_model", 8'(done_a), 8'(exp_done(t_a, A_N, A_H, A_G)));
        check("a_busy_model", 8'(busy_a), 8'(!exp_done(t_a, A_N, A_H, A_G)));
        check("b_rst_out_model", 8'(rst_out_b), exp_out(t_b, B_N, B_H, B_G));
        check("b_seq_done_model", 8'(done_b), 8'(exp_done(t_b, B_N, B_H, B_G)));
        check("b_busy_model", 8'(busy_b), 8'(!exp_done(t_b, B_N, B_H, B_G)));
    endtask

    task automatic check_a(input string name, input logic [2:0] out, input logic done);
        check({name, "_rst_out"}, 8'(rst_out_a), 8'(out));
        check({name, "_seq_done"}, 8'(done_a), 8'(done));
        check({name, "_busy"}, 8'(busy_a), 8'(!done));
    endtask

    // One clock edge with the given request levels; outputs checked 1 time
    // unit after the edge.
    task automatic tick(input logic sa, input logic sb);
        sw_a = sa;
        sw_b = sb;
        @(posedge clk);
        if (rst_n) begin
            t_a = sa ? 0 : t_a + 1;
            t_b = sb ? 0 : t_b + 1;
        end
        #1;
        check_model();
    endtask

    task automatic run(input int n, input logic sa);
        for (int i = 0; i < n; i++) tick(sa, 1'b0);
    endtask

    // Asserts rst_n off the clock edge, checks the reset values before any
    // edge can occur, then releases on a falling clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        t_a = 0;
        t_b = 0;
        check_a("async_rst", 3'b111, 1'b0);
        check("b_async_rst_out", 8'(rst_out_b), 8'd1);
        check("b_async_busy", 8'(busy_b), 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int         cycles;
        logic       sw;
        logic [2:0] exp_out;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Power-on, then a one-cycle request at edge 40.
        vecs.push_back('{14, 1'b0, 3'b111, 1'b0});  // edge 15
        vecs.push_back('{1,  1'b0, 3'b110, 1'b0});  // edge 16
        vecs.push_back('{3,  1'b0, 3'b110, 1'b0});  // edge 19
        vecs.push_back('{1,  1'b0, 3'b100, 1'b0});  // edge 20
        vecs.push_back('{3,  1'b0, 3'b100, 1'b0});  // edge 23
        vecs.push_back('{1,  1'b0, 3'b000, 1'b1});  // edge 24
        vecs.push_back('{15, 1'b0, 3'b000, 1'b1});  // edge 39
        vecs.push_back('{1,  1'b1, 3'b111, 1'b0});  // edge 40: request
        vecs.push_back('{15, 1'b0, 3'b111, 1'b0});  // edge 55
        vecs.push_back('{1,  1'b0, 3'b110, 1'b0});  // edge 56
        vecs.push_back('{4,  1'b0, 3'b100, 1'b0});  // edge 60
        vecs.push_back('{3,  1'b0, 3'b100, 1'b0});  // edge 63
        vecs.push_back('{1,  1'b0, 3'b000, 1'b1});  // edge 64

        rst_n = 1'b1;
        sw_a  = 1'b0;
        sw_b  = 1'b0;
        #2;
        do_reset();

        // Edge 1: B (single stage, hold 1) releases and completes at once.
        tick(1'b0, 1'b0);
        check_a("edge1", 3'b111, 1'b0);
        check("b_edge1_rst_out", 8'(rst_out_b), 8'd0);
        check("b_edge1_seq_done", 8'(done_b), 8'd1);
        check("b_edge1_busy", 8'(busy_b), 8'd0);

        foreach (vecs[i]) begin
            run(vecs[i].cycles, vecs[i].sw);
            check_a($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_done);
        end

        // Request mid-release at edge 18.
        do_reset();
        run(17, 1'b0);
        check_a("mid_e17", 3'b110, 1'b0);
        tick(1'b1, 1'b0);
        check_a("mid_e18", 3'b111, 1'b0);
        run(15, 1'b0);
        check_a("mid_e33", 3'b111, 1'b0);
        tick(1'b0, 1'b0);
        check_a("mid_e34", 3'b110, 1'b0);
        run(4, 1'b0);
        check_a("mid_e38", 3'b100, 1'b0);
        run(4, 1'b0);
        check_a("mid_e42", 3'b000, 1'b1);

        // Long request over edges 30..49.
        do_reset();
        run(29, 1'b0);
        check_a("long_e29", 3'b000, 1'b1);
        run(20, 1'b1);
        check_a("long_e49", 3'b111, 1'b0);
        run(15, 1'b0);
        check_a("long_e64", 3'b111, 1'b0);
        tick(1'b0, 1'b0);
        check_a("long_e65", 3'b110, 1'b0);
        run(4, 1'b0);
        check_a("long_e69", 3'b100, 1'b0);
        run(4, 1'b0);
        check_a("long_e73", 3'b000, 1'b1);

        // Asynchronous reset between edges 21 and 22, then a full restart.
        do_reset();
        run(21, 1'b0);
        check_a("arst_e21", 3'b100, 1'b0);
        #3;
        do_reset();
        run(15, 1'b0);
        check_a("arst_re15", 3'b111, 1'b0);
        tick(1'b0, 1'b0);
        check_a("arst_re16", 3'b110, 1'b0);
        run(8, 1'b0);
        check_a("arst_re24", 3'b000, 1'b1);

        // Random request traffic on both instances with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2;
                do_reset();
            end
            tick(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
